// File: rtl/fme_refine_ctrl_if.sv
// Handshake and data bundle between the fractional-ME refinement controller,
// the interpolation/SATD engine and the candidate selector.
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif
`ifndef FMVD_LEN
`define FMVD_LEN 10
`endif

interface fme_refine_ctrl_if #(
  parameter int unsigned SATD_BITS = `BIT_DEPTH + 10
);
  localparam int unsigned MV_W = `FMVD_LEN;

  logic                        start_i;
  logic signed [MV_W-1:0]      imv_x_i;
  logic signed [MV_W-1:0]      imv_y_i;
  logic [4:0]                  blk_num_i;
  logic                        part_valid_i;
  logic [SATD_BITS-1:0]        part0_i, part1_i, part2_i, part3_i, part4_i,
                               part5_i, part6_i, part7_i, part8_i;
  logic                        cost_valid_i;
  logic [SATD_BITS:0]          bcost_i;
  logic [1:0]                  bcand_x_i;
  logic [1:0]                  bcand_y_i;

  logic                        stage_start_o;
  logic                        half_o;
  logic signed [MV_W-1:0]      mv_x_o;
  logic signed [MV_W-1:0]      mv_y_o;
  logic                        satd_valid_o;
  logic [SATD_BITS-1:0]        satd0_o, satd1_o, satd2_o, satd3_o, satd4_o,
                               satd5_o, satd6_o, satd7_o, satd8_o;
  logic                        busy_o;
  logic                        done_o;
  logic signed [MV_W-1:0]      fmv_x_o;
  logic signed [MV_W-1:0]      fmv_y_o;
  logic [SATD_BITS:0]          fcost_o;

  // Controller side
  modport slave (
    input  start_i, imv_x_i, imv_y_i, blk_num_i, part_valid_i,
           part0_i, part1_i, part2_i, part3_i, part4_i,
           part5_i, part6_i, part7_i, part8_i,
           cost_valid_i, bcost_i, bcand_x_i, bcand_y_i,
    output stage_start_o, half_o, mv_x_o, mv_y_o, satd_valid_o,
           satd0_o, satd1_o, satd2_o, satd3_o, satd4_o,
           satd5_o, satd6_o, satd7_o, satd8_o,
           busy_o, done_o, fmv_x_o, fmv_y_o, fcost_o
  );

  // Environment side (engine + selector + requester)
  modport master (
    output start_i, imv_x_i, imv_y_i, blk_num_i, part_valid_i,
           part0_i, part1_i, part2_i, part3_i, part4_i,
           part5_i, part6_i, part7_i, part8_i,
           cost_valid_i, bcost_i, bcand_x_i, bcand_y_i,
    input  stage_start_o, half_o, mv_x_o, mv_y_o, satd_valid_o,
           satd0_o, satd1_o, satd2_o, satd3_o, satd4_o,
           satd5_o, satd6_o, satd7_o, satd8_o,
           busy_o, done_o, fmv_x_o, fmv_y_o, fcost_o
  );
endinterface

// File: rtl/fme_refine_ctrl.sv
// Two-stage (half-pel then quarter-pel) fractional MV refinement controller:
// accumulates 3x3 candidate SATDs per stage and steps the MV by the selector's pick.
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif
`ifndef FMVD_LEN
`define FMVD_LEN 10
`endif

module fme_refine_ctrl #(
  parameter int unsigned SATD_BITS = `BIT_DEPTH + 10
) (
  input logic               clk_i,
  input logic               rst_i,
  fme_refine_ctrl_if.slave  bus
);
  localparam int unsigned MV_W  = `FMVD_LEN;
  localparam int unsigned NCAND = 9;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {IDLE, H_ACC, H_WAIT, Q_ACC, Q_WAIT, DONE} state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       blk_q;
  logic [SATD_BITS-1:0]   acc_q   [NCAND];
  logic [SATD_BITS-1:0]   satd_q  [NCAND];
  logic [SATD_BITS-1:0]   part_c  [NCAND];
  logic [SATD_BITS-1:0]   acc_nxt_c [NCAND];
  logic [CNT_W-1:0]       cnt_inc_c;
  logic                   last_beat_c;

  logic                   stage_start_q;
  logic                   half_q;
  logic signed [MV_W-1:0] mv_x_q, mv_y_q;
  logic                   satd_valid_q;
  logic                   busy_q;
  logic                   done_q;
  logic signed [MV_W-1:0] fmv_x_q, fmv_y_q;
  logic [SATD_BITS:0]     fcost_q;

  // Offset code to signed step: 11 -> -1, 01 -> +1, others -> 0
  function automatic logic signed [MV_W-1:0] dec(input logic [1:0] code);
    case (code)
      2'b11:   return '1;
      2'b01:   return MV_W'(1);
      default: return '0;
    endcase
  endfunction

  // Gather partials and form saturating next-accumulator values
  always_comb begin
    part_c[0] = bus.part0_i;
    part_c[1] = bus.part1_i;
    part_c[2] = bus.part2_i;
    part_c[3] = bus.part3_i;
    part_c[4] = bus.part4_i;
    part_c[5] = bus.part5_i;
    part_c[6] = bus.part6_i;
    part_c[7] = bus.part7_i;
    part_c[8] = bus.part8_i;
    for (int unsigned k = 0; k < NCAND; k++) begin
      logic [SATD_BITS:0] sum;
      sum = {1'b0, acc_q[k]} + {1'b0, part_c[k]};
      acc_nxt_c[k] = sum[SATD_BITS] ? '1 : sum[SATD_BITS-1:0];
    end
    cnt_inc_c   = cnt_q + CNT_W'(1);
    last_beat_c = (cnt_inc_c == blk_q);
  end

  // Refinement FSM with registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      blk_q         <= '0;
      stage_start_q <= 1'b0;
      half_q        <= 1'b0;
      mv_x_q        <= '0;
      mv_y_q        <= '0;
      satd_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fmv_x_q       <= '0;
      fmv_y_q       <= '0;
      fcost_q       <= '0;
      for (int unsigned k = 0; k < NCAND; k++) begin
        acc_q[k]  <= '0;
        satd_q[k] <= '0;
      end
    end else begin
      stage_start_q <= 1'b0;
      satd_valid_q  <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            mv_x_q        <= bus.imv_x_i;
            mv_y_q        <= bus.imv_y_i;
            blk_q         <= (bus.blk_num_i == '0) ? CNT_W'(1) : bus.blk_num_i;
            cnt_q         <= '0;
            for (int unsigned k = 0; k < NCAND; k++) acc_q[k] <= '0;
            stage_start_q <= 1'b1;
            half_q        <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= H_ACC;
          end
        end
        H_ACC, Q_ACC: begin
          if (bus.part_valid_i) begin
            cnt_q <= cnt_inc_c;
            for (int unsigned k = 0; k < NCAND; k++) acc_q[k] <= acc_nxt_c[k];
            if (last_beat_c) begin
              for (int unsigned k = 0; k < NCAND; k++) satd_q[k] <= acc_nxt_c[k];
              satd_valid_q <= 1'b1;
              state_q      <= (state_q == H_ACC) ? H_WAIT : Q_WAIT;
            end
          end
        end
        H_WAIT: begin
          if (bus.cost_valid_i) begin
            mv_x_q        <= mv_x_q + dec(bus.bcand_x_i) + dec(bus.bcand_x_i);
            mv_y_q        <= mv_y_q + dec(bus.bcand_y_i) + dec(bus.bcand_y_i);
            cnt_q         <= '0;
            for (int unsigned k = 0; k < NCAND; k++) acc_q[k] <= '0;
            stage_start_q <= 1'b1;
            half_q        <= 1'b0;
            state_q       <= Q_ACC;
          end
        end
        Q_WAIT: begin
          if (bus.cost_valid_i) begin
            fmv_x_q <= mv_x_q + dec(bus.bcand_x_i);
            fmv_y_q <= mv_y_q + dec(bus.bcand_y_i);
            fcost_q <= bus.bcost_i;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Drive the bundle from the output registers
  assign bus.stage_start_o = stage_start_q;
  assign bus.half_o        = half_q;
  assign bus.mv_x_o        = mv_x_q;
  assign bus.mv_y_o        = mv_y_q;
  assign bus.satd_valid_o  = satd_valid_q;
  assign bus.satd0_o       = satd_q[0];
  assign bus.satd1_o       = satd_q[1];
  assign bus.satd2_o       = satd_q[2];
  assign bus.satd3_o       = satd_q[3];
  assign bus.satd4_o       = satd_q[4];
  assign bus.satd5_o       = satd_q[5];
  assign bus.satd6_o       = satd_q[6];
  assign bus.satd7_o       = satd_q[7];
  assign bus.satd8_o       = satd_q[8];
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.fmv_x_o       = fmv_x_q;
  assign bus.fmv_y_o       = fmv_y_q;
  assign bus.fcost_o       = fcost_q;
endmodule

// File: tb/tb_fme_refine_ctrl.sv
// Directed bench for fme_refine_ctrl: reset, two-stage refinement, long stages,
// saturation, ignored strobes, mid-run reset and MV wrap-around.
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif
`ifndef FMVD_LEN
`define FMVD_LEN 10
`endif

module tb_fme_refine_ctrl;
  localparam int unsigned SB = `BIT_DEPTH + 10;
  localparam logic [SB-1:0] MAXS = {SB{1'b1}};

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   pulses;

  fme_refine_ctrl_if #(.SATD_BITS(SB)) bus ();
  fme_refine_ctrl #(.SATD_BITS(SB)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_parts(input bool_kp1, input logic [SB-1:0] v);
    bus.part0_i = bool_kp1 ? SB'(1) : v;
    bus.part1_i = bool_kp1 ? SB'(2) : v;
    bus.part2_i = bool_kp1 ? SB'(3) : v;
    bus.part3_i = bool_kp1 ? SB'(4) : v;
    bus.part4_i = bool_kp1 ? SB'(5) : v;
    bus.part5_i = bool_kp1 ? SB'(6) : v;
    bus.part6_i = bool_kp1 ? SB'(7) : v;
    bus.part7_i = bool_kp1 ? SB'(8) : v;
    bus.part8_i = bool_kp1 ? SB'(9) : v;
  endtask

  task automatic start(input int x, input int y, input int blk);
    bus.imv_x_i   = `FMVD_LEN'(x);
    bus.imv_y_i   = `FMVD_LEN'(y);
    bus.blk_num_i = 5'(blk);
    bus.start_i   = 1'b1;
    tick();
    bus.start_i   = 1'b0;
  endtask

  task automatic cost(input logic [1:0] bx, input logic [1:0] by, input int c);
    bus.bcand_x_i    = bx;
    bus.bcand_y_i    = by;
    bus.bcost_i      = (SB+1)'(c);
    bus.cost_valid_i = 1'b1;
    tick();
    bus.cost_valid_i = 1'b0;
  endtask

  initial begin
    bus.start_i = 0; bus.imv_x_i = '0; bus.imv_y_i = '0; bus.blk_num_i = '0;
    bus.part_valid_i = 0; bus.cost_valid_i = 0; bus.bcost_i = '0;
    bus.bcand_x_i = '0; bus.bcand_y_i = '0;
    set_parts(1'b0, '0);

    // Reset state
    tick(); tick();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_stage_start", bus.stage_start_o, 0);
    chk("rst_satd_valid", bus.satd_valid_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_half", bus.half_o, 0);
    chk("rst_mv_x", bus.mv_x_o, 0);
    rst_i = 1'b0;
    tick();

    // Basic two-stage refinement: imv (8,-4), blk 1, parts k+1
    start(8, -4, 1);
    chk("t1_busy", bus.busy_o, 1);
    chk("t1_hstart", bus.stage_start_o, 1);
    chk("t1_half", bus.half_o, 1);
    chk("t1_mv_x0", bus.mv_x_o, 8);
    chk("t1_mv_y0", bus.mv_y_o, -4);
    set_parts(1'b1, '0);
    bus.part_valid_i = 1; tick(); bus.part_valid_i = 0;
    chk("t1_hvalid", bus.satd_valid_o, 1);
    chk("t1_satd4", bus.satd4_o, 5);
    chk("t1_satd0", bus.satd0_o, 1);
    chk("t1_satd8", bus.satd8_o, 9);
    chk("t1_hstart_off", bus.stage_start_o, 0);
    tick();
    chk("t1_hvalid_off", bus.satd_valid_o, 0);
    cost(2'b01, 2'b11, 0);
    chk("t1_qstart", bus.stage_start_o, 1);
    chk("t1_qhalf", bus.half_o, 0);
    chk("t1_mv_x1", bus.mv_x_o, 10);
    chk("t1_mv_y1", bus.mv_y_o, -6);
    bus.part_valid_i = 1; tick(); bus.part_valid_i = 0;
    chk("t1_qvalid", bus.satd_valid_o, 1);
    // start during Q_WAIT must be ignored
    start(100, 100, 3);
    chk("t1_qwait_mv", bus.mv_x_o, 10);
    chk("t1_qwait_busy", bus.busy_o, 1);
    chk("t1_qwait_done", bus.done_o, 0);
    cost(2'b11, 2'b00, 100);
    chk("t1_done", bus.done_o, 1);
    chk("t1_fmv_x", bus.fmv_x_o, 9);
    chk("t1_fmv_y", bus.fmv_y_o, -6);
    chk("t1_fcost", bus.fcost_o, 100);
    tick();
    chk("t1_done_off", bus.done_o, 0);
    chk("t1_idle", bus.busy_o, 0);
    chk("t1_fcost_hold", bus.fcost_o, 100);

    // 16-beat stages, every part 10; stray cost in H_ACC is ignored
    start(0, 0, 16);
    cost(2'b01, 2'b01, 55);
    chk("t2_stray_mv", bus.mv_x_o, 0);
    chk("t2_stray_start", bus.stage_start_o, 0);
    chk("t2_stray_half", bus.half_o, 1);
    set_parts(1'b0, SB'(10));
    pulses = 0;
    bus.part_valid_i = 1;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (bus.satd_valid_o) pulses++;
    end
    chk("t2_hpulses", pulses, 1);
    chk("t2_hsatd0", bus.satd0_o, 160);
    chk("t2_hsatd4", bus.satd4_o, 160);
    chk("t2_hsatd8", bus.satd8_o, 160);
    // part_valid and cost_valid together in H_WAIT: only cost acts
    cost(2'b00, 2'b00, 0);
    chk("t2_qstart", bus.stage_start_o, 1);
    chk("t2_qhalf", bus.half_o, 0);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.satd_valid_o) pulses++;
    end
    bus.part_valid_i = 0;
    chk("t2_qpulses", pulses, 1);
    chk("t2_qsatd3", bus.satd3_o, 160);
    chk("t2_qsatd7", bus.satd7_o, 160);
    cost(2'b01, 2'b11, 7);
    chk("t2_done", bus.done_o, 1);
    chk("t2_fmv_x", bus.fmv_x_o, 1);
    chk("t2_fmv_y", bus.fmv_y_o, -1);
    chk("t2_fcost", bus.fcost_o, 7);
    tick();

    // Saturation over two beats, then reset in Q_ACC
    start(3, 3, 2);
    set_parts(1'b0, '0);
    bus.part0_i = MAXS;
    bus.part_valid_i = 1; tick(); tick(); bus.part_valid_i = 0;
    chk("t3_valid", bus.satd_valid_o, 1);
    chk("t3_sat0", bus.satd0_o, MAXS);
    chk("t3_satd1", bus.satd1_o, 0);
    cost(2'b00, 2'b01, 0);
    chk("t3_mv_y", bus.mv_y_o, 5);
    bus.part_valid_i = 1; tick(); bus.part_valid_i = 0;
    rst_i = 1; tick(); rst_i = 0;
    chk("t3_rst_busy", bus.busy_o, 0);
    chk("t3_rst_satd0", bus.satd0_o, 0);
    chk("t3_rst_mv_y", bus.mv_y_o, 0);
    chk("t3_rst_fcost", bus.fcost_o, 0);
    chk("t3_rst_fmv_x", bus.fmv_x_o, 0);
    chk("t3_rst_done", bus.done_o, 0);
    tick();
    chk("t3_nodone", bus.done_o, 0);

    // Restart after reset; blk 0 acts as 1; MV x wraps
    start(511, 0, 0);
    chk("t4_hstart", bus.stage_start_o, 1);
    set_parts(1'b1, '0);
    bus.part_valid_i = 1; tick(); bus.part_valid_i = 0;
    chk("t4_hvalid", bus.satd_valid_o, 1);
    cost(2'b01, 2'b00, 0);
    chk("t4_mv_wrap", bus.mv_x_o, -511);
    bus.part_valid_i = 1; tick(); bus.part_valid_i = 0;
    chk("t4_qvalid", bus.satd_valid_o, 1);
    cost(2'b01, 2'b00, 42);
    chk("t4_done", bus.done_o, 1);
    chk("t4_fmv_x", bus.fmv_x_o, -510);
    chk("t4_fmv_y", bus.fmv_y_o, 0);
    chk("t4_fcost", bus.fcost_o, 42);
    tick();
    chk("t4_idle", bus.busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fme_refine_ctrl.md
FME_REFINE_CTRL -- requirements
Module: fme_refine_ctrl

Interface
REQ-001 Parameter SATD_BITS, default `BIT_DEPTH + 10, width of the SATD partials, the SATD sums and the candidate-selector SATD inputs.
REQ-002 Macro `FMVD_LEN sets the width of every signed MV port; MVs are in quarter-pel units.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  clock; all state changes on the rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 start_i  in  1  one-cycle request to refine one partition; honoured only in IDLE.
REQ-007 imv_x_i, imv_y_i  in  `FMVD_LEN each  signed integer-pel MV (quarter units), sampled with start_i.
REQ-008 blk_num_i  in  5  number of partial-SATD beats per stage (1..16), sampled with start_i.
REQ-009 part_valid_i  in  1  one beat of partial SATDs is present.
REQ-010 part0_i..part8_i  in  SATD_BITS each  partial SATDs for candidates 0..8 (row-major 3x3, 4 = centre).
REQ-011 cost_valid_i  in  1  result strobe from the candidate selector.
REQ-012 bcost_i  in  SATD_BITS+1  best cost from the candidate selector.
REQ-013 bcand_x_i, bcand_y_i  in  2 each  best offset code: 2'b11 = -1 step, 2'b00 = 0, 2'b01 = +1 step.
REQ-014 stage_start_o  out  1  one-cycle pulse telling the interpolation/SATD engine to begin a stage.
REQ-015 half_o  out  1  1 = half-pel stage, 0 = quarter-pel stage; drives the selector's half input.
REQ-016 mv_x_o, mv_y_o  out  `FMVD_LEN each  current stage centre MV.
REQ-017 satd_valid_o  out  1  one-cycle pulse; satd0_o..satd8_o are valid.
REQ-018 satd0_o..satd8_o  out  SATD_BITS each  accumulated SATD per candidate.
REQ-019 busy_o  out  1  high in every state except IDLE.
REQ-020 done_o  out  1  one-cycle pulse; fmv_x_o, fmv_y_o and fcost_o are valid.
REQ-021 fmv_x_o, fmv_y_o  out  `FMVD_LEN each; fcost_o  out  SATD_BITS+1  final refined MV and cost.

Function
REQ-022 States: IDLE, H_ACC, H_WAIT, Q_ACC, Q_WAIT, DONE.
REQ-023 IDLE + start_i: latch imv and blk_num (0 is treated as 1), clear the accumulators and the beat counter, then go to H_ACC.
REQ-024 One cycle after entering H_ACC: stage_start_o = 1, half_o = 1, mv_o = latched imv.
REQ-025 In H_ACC/Q_ACC each part_valid_i beat adds part_k to acc_k (k = 0..8) and increments the beat counter.
REQ-026 An accumulator that would exceed 2^SATD_BITS-1 saturates at 2^SATD_BITS-1.
REQ-027 On the beat that makes count == blk_num: the cycle after, satd_valid_o = 1 with satd_k_o = the final acc_k (that beat included); the state moves to H_WAIT/Q_WAIT.
REQ-028 satd_k_o hold their value until the next stage's satd_valid_o.
REQ-029 H_WAIT + cost_valid_i: mv_o += 2*dec(bcand) per axis, with dec(11) = -1, dec(00) = 0, dec(01) = +1, dec(10) = 0.
REQ-030 On that same H_WAIT transition: clear the accumulators and the counter, then go to Q_ACC; stage_start_o pulses the next cycle with half_o = 0 and the updated mv_o.
REQ-031 Q_WAIT + cost_valid_i: fmv = mv_o + 1*dec(bcand) per axis, fcost = bcost_i, then go to DONE.
REQ-032 DONE lasts one cycle with done_o = 1, then returns to IDLE; fmv and fcost hold until the next done_o.
REQ-033 All MV arithmetic wraps modulo 2^`FMVD_LEN (two's complement); no clamping.
REQ-034 part_valid_i outside H_ACC/Q_ACC is ignored; cost_valid_i outside H_WAIT/Q_WAIT is ignored.
REQ-035 start_i while busy_o = 1 is ignored.
REQ-036 Extra part_valid_i after the last beat (in a WAIT state) is ignored.
REQ-037 Simultaneous part_valid_i and cost_valid_i in a WAIT state: only cost_valid_i acts.
REQ-038 Best-case latency from start_i to done_o: 2*(blk_num + 1) + selector latency + 3 cycles.

Reset
REQ-039 rst_i = 1 at a clock edge forces IDLE, aborts any refinement in progress without a done_o, and drives every output to 0: stage_start_o, half_o, mv_o, satd_valid_o, satd_k_o, busy_o, done_o, fmv_o, fcost_o.
REQ-040 The accumulators, beat counter, and latched imv/blk_num also reset to 0.

Verification
REQ-041 Setup: imv = (8, -4), blk_num = 1, parts = k+1. Response: satd_valid_o with satd4_o = 5. Then bcand = (01, 11), then bcand = (11, 00), bcost = 100. Response: half stage mv_o = (10, -6); done_o with fmv = (9, -6), fcost = 100.
REQ-042 Setup: blk_num = 16, every part_k = 10. Response: satd_k_o = 160 for every k; exactly one satd_valid_o per stage.
REQ-043 Setup: blk_num = 2, part0 = 2^SATD_BITS-1 on both beats. Response: satd0_o = 2^SATD_BITS-1 (saturated).
REQ-044 Stimulus: start_i during Q_WAIT, and a stray cost_valid_i during H_ACC. Response: no state change and no mv change.
REQ-045 Stimulus: rst_i asserted in Q_ACC. Response: all outputs 0 and IDLE next cycle; no done_o; a following start_i completes normally.
REQ-046 Setup: imv_x = 2^(`FMVD_LEN-1)-1, bcand_x = 01 in both stages. Response: fmv_x wraps to -2^(`FMVD_LEN-1)+2.
